tlc_monitor: RTL and testbench

Receive-side checker for the fixed-time traffic light controller's one-hot `colour` bus. It samples `colour` every clock and decodes it to a phase index. It tracks how long each colour is held and checks the RED→GREEN→YELLOW→RED order and the dwell limits. It reports single-cycle error pulses, a sticky summary and a completed-cycle count. It sits beside the controller in the intersection subsystem and feeds status/interrupt logic.

---
 rtl/tlc_pkg.sv | 14 +
 rtl/tlc_colour_dec.sv | 11 +
 rtl/tlc_monitor.sv | 96 +++++++++
 tb/tb_tlc_monitor.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: colour constants, phase/state types and legal-successor helper for the traffic light monitor
package tlc_pkg;
    localparam logic [2:0] NONE   = 3'b000;
    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b100;

    typedef enum logic [1:0] {PH_RED = 2'd0, PH_GREEN = 2'd1, PH_YELLOW = 2'd2, PH_INV = 2'd3} phase_t;
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} mon_state_t;

    function automatic logic [2:0] next_colour(input logic [2:0] col);
        return col == RED ? GREEN : col == GREEN ? YELLOW : col == YELLOW ? RED : NONE;
    endfunction
endpackage

// File: rtl/tlc_colour_dec.sv
// tlc_colour_dec: combinational one-hot check and phase decode of the lamp bus
module tlc_colour_dec
    import tlc_pkg::*;
(
    input  logic [2:0] colour,
    output logic       valid,
    output phase_t     phase
);
    assign valid = $onehot(colour);
    assign phase = colour == RED ? PH_RED : colour == GREEN ? PH_GREEN : colour == YELLOW ? PH_YELLOW : PH_INV;
endmodule

// File: rtl/tlc_monitor.sv
// tlc_monitor: colour order / dwell checker with error pulses; TLC_MON_CYCLE_CNT_EN builds cycle_cnt
module tlc_monitor
    import tlc_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1,
    parameter int CNT_W     = 4
) (
    input  logic             c,
    input  logic             r,
    input  logic [2:0]       colour,
    input  logic             err_clr,
    output logic [1:0]       phase,
    output logic             valid,
    output logic             locked,
    output logic [CNT_W-1:0] dwell,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_short,
    output logic             err_long,
    output logic             err_sticky,
    output logic [7:0]       cycle_cnt
);
    logic             dv;
    phase_t           dp;
    mon_state_t       state, state_n;
    logic [2:0]       prev;
    logic [CNT_W-1:0] dwell_n;
    logic             same, legal, oh_n, seq_n, short_n, long_n;

    tlc_colour_dec u_dec (.colour(colour), .valid(dv), .phase(dp));

    assign same   = dv && colour == prev;
    assign legal  = dv && prev != NONE && colour == next_colour(prev);
    assign locked = state == LOCKED;

    always_comb begin
        state_n = state;
        dwell_n = CNT_W'(1);
        oh_n    = !dv;
        seq_n   = 1'b0;
        short_n = 1'b0;
        long_n  = 1'b0;
        if (!dv) begin
            state_n = UNLOCKED;
            dwell_n = '0;
        end else if (same) begin
            dwell_n = &dwell ? dwell : dwell + 1'b1;
            long_n  = state == LOCKED && dwell == CNT_W'(MAX_DWELL);
        end else if (legal) begin
            state_n = LOCKED;
            short_n = state == LOCKED && dwell < CNT_W'(MIN_DWELL);
        end else if (prev != NONE) begin
            seq_n   = 1'b1;
            state_n = UNLOCKED;
        end
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state      <= UNLOCKED;
            prev       <= NONE;
            phase      <= PH_INV;
            valid      <= 1'b0;
            dwell      <= '0;
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_n;
            prev       <= dv ? colour : NONE;
            phase      <= dp;
            valid      <= dv;
            dwell      <= dwell_n;
            err_onehot <= oh_n;
            err_seq    <= seq_n;
            err_short  <= short_n;
            err_long   <= long_n;
            // a pulse in the clearing cycle keeps the flag set
            err_sticky <= (err_sticky & ~err_clr) | oh_n | seq_n | short_n | long_n;
        end
    end

`ifdef TLC_MON_CYCLE_CNT_EN
    always_ff @(posedge c or posedge r) begin
        if (r)
            cycle_cnt <= '0;
        else if (legal && state == LOCKED && colour == RED)
            cycle_cnt <= cycle_cnt + 8'd1;
    end
`else
    assign cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_tlc_monitor.sv
// tb_tlc_monitor: runs a default and a MIN=2/MAX=3 monitor side by side against a run-length model
module tb_tlc_monitor;
    localparam logic [2:0] R = 3'b001, G = 3'b010, Y = 3'b100;

    logic       c = 0, r = 0, err_clr = 0;
    logic [2:0] colour = 3'b000;
    logic [1:0] ph[2];
    logic [3:0] dw[2];
    logic [7:0] cc[2];
    logic       vl[2], lk[2], oh[2], sq[2], sh[2], lg[2], st[2];

    int n_cmp = 0, n_bad = 0;

    tlc_monitor #(.MIN_DWELL(1), .MAX_DWELL(1), .CNT_W(4)) d0 (
        .c(c), .r(r), .colour(colour), .err_clr(err_clr), .phase(ph[0]), .valid(vl[0]), .locked(lk[0]),
        .dwell(dw[0]), .err_onehot(oh[0]), .err_seq(sq[0]), .err_short(sh[0]), .err_long(lg[0]),
        .err_sticky(st[0]), .cycle_cnt(cc[0]));

    tlc_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .CNT_W(4)) d1 (
        .c(c), .r(r), .colour(colour), .err_clr(err_clr), .phase(ph[1]), .valid(vl[1]), .locked(lk[1]),
        .dwell(dw[1]), .err_onehot(oh[1]), .err_seq(sq[1]), .err_short(sh[1]), .err_long(lg[1]),
        .err_sticky(st[1]), .cycle_cnt(cc[1]));

    always #5 c = ~c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: phase index 0..2, run length as an unbounded integer, successor means (idx-last) mod 3 == 1
    int   min_d[2] = '{1, 2};
    int   max_d[2] = '{1, 3};
    int   last[2]  = '{-1, -1};
    int   run[2]   = '{0, 0};
    int   cyc[2]   = '{0, 0};
    bit   sync[2]  = '{0, 0};
    bit   stk[2]   = '{0, 0};
    int   e_ph[2]  = '{3, 3};
    bit   e_oh[2], e_sq[2], e_sh[2], e_lg[2];

    always @(posedge c or posedge r) begin
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                last[k] = -1; run[k] = 0; cyc[k] = 0; sync[k] = 0; stk[k] = 0; e_ph[k] = 3;
                e_oh[k] = 0; e_sq[k] = 0; e_sh[k] = 0; e_lg[k] = 0;
            end else begin
                int idx;
                idx = colour == R ? 0 : colour == G ? 1 : colour == Y ? 2 : -1;
                e_oh[k] = 0; e_sq[k] = 0; e_sh[k] = 0; e_lg[k] = 0;
                if (idx < 0) begin
                    e_oh[k] = 1; run[k] = 0; sync[k] = 0;
                end else if (last[k] < 0) begin
                    run[k] = 1;
                end else if (idx == last[k]) begin
                    run[k]++;
                    e_lg[k] = sync[k] && run[k] == max_d[k] + 1;
                end else if (idx == (last[k] + 1) % 3) begin
                    e_sh[k] = sync[k] && run[k] < min_d[k];
`ifdef TLC_MON_CYCLE_CNT_EN
                    if (sync[k] && idx == 0) cyc[k] = (cyc[k] + 1) % 256;
`endif
                    sync[k] = 1; run[k] = 1;
                end else begin
                    e_sq[k] = 1; sync[k] = 0; run[k] = 1;
                end
                last[k] = idx;
                e_ph[k] = idx < 0 ? 3 : idx;
                stk[k] = (err_clr ? 1'b0 : stk[k]) | e_oh[k] | e_sq[k] | e_sh[k] | e_lg[k];
            end
        end
    end

    always @(negedge c) begin
        for (int k = 0; k < 2; k++) begin
            logic [20:0] act, exp;
            act = {ph[k], vl[k], lk[k], dw[k], oh[k], sq[k], sh[k], lg[k], st[k], cc[k]};
            exp = {2'(e_ph[k]), e_ph[k] != 3, sync[k], 4'(run[k] > 15 ? 15 : run[k]),
                   e_oh[k], e_sq[k], e_sh[k], e_lg[k], stk[k], 8'(cyc[k])};
            chk($sformatf("model_d%0d", k), 32'(act), 32'(exp));
        end
    end

    task automatic step(input logic [2:0] col, input logic clr = 1'b0);
        colour = col;
        err_clr = clr;
        @(posedge c);
        #1;
    endtask

    initial begin
        #1 r = 1;
        #2;
        chk("rst_phase", 32'(ph[0]), 3);
        chk("rst_valid", 32'(vl[0]), 0);
        chk("rst_dwell", 32'(dw[0]), 0);
        chk("rst_locked", 32'(lk[0]), 0);
        repeat (3) @(posedge c);
        #1 r = 0;
        // default sequence, one sample per colour
        step(R); chk("s1_unlocked_first", 32'(lk[0]), 0);
        step(G); chk("s1_locked_second", 32'(lk[0]), 1);
        step(Y);
        repeat (2) begin step(R); step(G); step(Y); end
        step(R);
`ifdef TLC_MON_CYCLE_CNT_EN
        chk("s1_cycle_cnt", 32'(cc[0]), 3);
`else
        chk("s1_cycle_cnt", 32'(cc[0]), 0);
`endif
        chk("s1_sticky", 32'(st[0]), 0);
        // overlong GREEN
        step(G); chk("s2_long_g1", 32'(lg[0]), 0);
        step(G); chk("s2_long_g2", 32'(lg[0]), 1);
        step(G); chk("s2_long_g3", 32'(lg[0]), 0); chk("s2_dwell", 32'(dw[0]), 3); chk("s2_sticky", 32'(st[0]), 1);
        // illegal RED->YELLOW then re-lock
        step(Y); step(R); chk("s3_locked", 32'(lk[0]), 1);
        step(Y); chk("s3_seq", 32'(sq[0]), 1); chk("s3_unlock", 32'(lk[0]), 0);
        step(R); chk("s3_seq_clear", 32'(sq[0]), 0); chk("s3_relock", 32'(lk[0]), 1);
        // not one-hot, then clear sticky
        step(G);
        step(3'b011);
        chk("s4_onehot", 32'(oh[0]), 1); chk("s4_phase", 32'(ph[0]), 3);
        chk("s4_valid", 32'(vl[0]), 0); chk("s4_locked", 32'(lk[0]), 0);
        step(R, 1'b1); chk("s4_sticky_clr", 32'(st[0]), 0);
        // short YELLOW on the MIN_DWELL=2 instance
        step(R); step(G); step(G); step(Y); step(R);
        chk("s5_short_d1", 32'(sh[1]), 1);
        chk("s5_short_d0", 32'(sh[0]), 0);
        // asynchronous reset mid-GREEN
        step(G);
        #1 r = 1;
        #1;
        chk("s6_phase", 32'(ph[0]), 3); chk("s6_locked", 32'(lk[0]), 0);
        chk("s6_dwell", 32'(dw[0]), 0); chk("s6_sticky", 32'(st[1]), 0);
        chk("s6_cycle", 32'(cc[0]), 0); chk("s6_valid", 32'(vl[0]), 0);
        repeat (2) @(posedge c);
        #1 r = 0;
        step(R); chk("s6_unlocked", 32'(lk[0]), 0);
        step(G); chk("s6_relock", 32'(lk[0]), 1);
        step(Y); step(R);
        @(negedge c);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
